// File: rtl/branch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : branch_pkg
// Purpose  : Shared definitions for the branch resolution controller:
//            branch funct3 encodings, controller state encoding and the
//            default datapath width.
// Revision : 1.0 - initial release
// ============================================================================
package branch_pkg;

  localparam int XLEN_DEFAULT = 32;

  // RV32I conditional-branch funct3 encodings (010/011 are reserved)
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CMP   = 2'd1,
    ISSUE = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/branch_cmp_core.sv
`default_nettype none
// ============================================================================
// Module   : branch_cmp_core
// Purpose  : Combinational branch condition evaluator covering all six RV32I
//            conditional branches.
// Ports    : in1, in2  - operands (rs1, rs2)
//            funct3    - branch condition select
//            take      - condition holds (0 when funct3 is illegal)
//            illegal   - funct3 is a reserved encoding (010 / 011)
// Revision : 1.0 - initial release
// ============================================================================
module branch_cmp_core
  import branch_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [XLEN-1:0] in1,
  input  logic [XLEN-1:0] in2,
  input  logic [2:0]      funct3,
  output logic            take,
  output logic            illegal
);

  logic eq;
  logic lt_s;
  logic lt_u;

  assign eq   = (in1 == in2);
  assign lt_s = ($signed(in1) < $signed(in2));
  assign lt_u = (in1 < in2);

  always_comb begin
    take    = 1'b0;
    illegal = 1'b0;
    case (funct3)
      F3_BEQ:  take = eq;
      F3_BNE:  take = ~eq;
      F3_BLT:  take = lt_s;
      F3_BGE:  take = ~lt_s;
      F3_BLTU: take = lt_u;
      F3_BGEU: take = ~lt_u;
      default: illegal = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/branch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : branch_ctrl
// Purpose  : Branch resolution sequencer. Accepts one branch from decode,
//            registers its operands, evaluates the condition, and on a taken
//            aligned branch offers a redirect to fetch, pulsing FLUSH on the
//            accepting cycle.
// Ports    : clk, rst_n                  - clock, async active-low reset
//            req_valid/req_ready         - decode handshake
//            req_funct3/pc/imm, in1/in2  - branch request payload
//            redir_valid/ready, redir_pc - redirect handshake to fetch
//            flush, done, taken, err     - single-cycle status pulses
//            taken_cnt, ntaken_cnt       - outcome counters (BRANCH_STATS_EN)
// Config   : define BRANCH_STATS_EN to add saturating outcome counters.
// Revision : 1.0 - initial release
// ============================================================================
module branch_ctrl
  import branch_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_funct3,
  input  logic [XLEN-1:0]  req_pc,
  input  logic [XLEN-1:0]  req_imm,
  input  logic [XLEN-1:0]  in1,
  input  logic [XLEN-1:0]  in2,
  output logic             redir_valid,
  input  logic             redir_ready,
  output logic [XLEN-1:0]  redir_pc,
  output logic             flush,
  output logic             done,
  output logic             taken,
`ifdef BRANCH_STATS_EN
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] ntaken_cnt,
`endif
  output logic             err
);

  state_e            state_q, state_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   imm_q, imm_d;
  logic [XLEN-1:0]   in1_q, in1_d;
  logic [XLEN-1:0]   in2_q, in2_d;
  logic [XLEN-1:0]   redir_pc_q, redir_pc_d;

  logic              cmp_take;
  logic              cmp_illegal;
  logic [XLEN-1:0]   target;

  branch_cmp_core #(.XLEN(XLEN)) u_cmp (
    .in1     (in1_q),
    .in2     (in2_q),
    .funct3  (funct3_q),
    .take    (cmp_take),
    .illegal (cmp_illegal)
  );

  // Wrapping add: the carry out is intentionally dropped.
  assign target = pc_q + imm_q;

  assign req_ready   = (state_q == IDLE);
  assign redir_valid = (state_q == ISSUE);
  assign redir_pc    = redir_pc_q;

  always_comb begin
    state_d    = state_q;
    funct3_d   = funct3_q;
    pc_d       = pc_q;
    imm_d      = imm_q;
    in1_d      = in1_q;
    in2_d      = in2_q;
    redir_pc_d = redir_pc_q;
    flush      = 1'b0;
    done       = 1'b0;
    taken      = 1'b0;
    err        = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          funct3_d = req_funct3;
          pc_d     = req_pc;
          imm_d    = req_imm;
          in1_d    = in1;
          in2_d    = in2;
          state_d  = CMP;
        end
      end
      CMP: begin
        if (cmp_illegal) begin
          err     = 1'b1;
          done    = 1'b1;
          state_d = IDLE;
        end else if (cmp_take) begin
          if (target[1:0] != 2'b00) begin
            // Misaligned target: resolve as an error, never redirect.
            err     = 1'b1;
            done    = 1'b1;
            state_d = IDLE;
          end else begin
            redir_pc_d = target;
            state_d    = ISSUE;
          end
        end else begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (redir_ready) begin
          flush   = 1'b1;
          done    = 1'b1;
          taken   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      funct3_q   <= '0;
      pc_q       <= '0;
      imm_q      <= '0;
      in1_q      <= '0;
      in2_q      <= '0;
      redir_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      funct3_q   <= funct3_d;
      pc_q       <= pc_d;
      imm_q      <= imm_d;
      in1_q      <= in1_d;
      in2_q      <= in2_d;
      redir_pc_q <= redir_pc_d;
    end
  end

`ifdef BRANCH_STATS_EN
  logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;
  logic [CNT_W-1:0] ntaken_cnt_q, ntaken_cnt_d;

  // Error resolutions report taken=0 and therefore count as not-taken.
  always_comb begin
    taken_cnt_d  = taken_cnt_q;
    ntaken_cnt_d = ntaken_cnt_q;
    if (done && taken && (taken_cnt_q != {CNT_W{1'b1}})) begin
      taken_cnt_d = taken_cnt_q + 1'b1;
    end
    if (done && !taken && (ntaken_cnt_q != {CNT_W{1'b1}})) begin
      ntaken_cnt_d = ntaken_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taken_cnt_q  <= '0;
      ntaken_cnt_q <= '0;
    end else begin
      taken_cnt_q  <= taken_cnt_d;
      ntaken_cnt_q <= ntaken_cnt_d;
    end
  end

  assign taken_cnt  = taken_cnt_q;
  assign ntaken_cnt = ntaken_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_ctrl
// Purpose  : Directed self-checking bench for branch_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_funct3;
  logic [31:0] req_pc;
  logic [31:0] req_imm;
  logic [31:0] in1;
  logic [31:0] in2;
  logic        redir_valid;
  logic        redir_ready;
  logic [31:0] redir_pc;
  logic        flush;
  logic        done;
  logic        taken;
  logic        err;
`ifdef BRANCH_STATS_EN
  logic [15:0] taken_cnt;
  logic [15:0] ntaken_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  branch_ctrl #(.XLEN(32), .CNT_W(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_funct3  (req_funct3),
    .req_pc      (req_pc),
    .req_imm     (req_imm),
    .in1         (in1),
    .in2         (in2),
    .redir_valid (redir_valid),
    .redir_ready (redir_ready),
    .redir_pc    (redir_pc),
    .flush       (flush),
    .done        (done),
    .taken       (taken),
`ifdef BRANCH_STATS_EN
    .taken_cnt   (taken_cnt),
    .ntaken_cnt  (ntaken_cnt),
`endif
    .err         (err)
  );

  // Presents one request for a single accepting edge; returns at the
  // falling edge of the CMP cycle (cycle 1).
  task automatic send(input logic [2:0] f3, input logic [31:0] pc,
                      input logic [31:0] imm, input logic [31:0] a,
                      input logic [31:0] b);
    @(negedge clk);
    req_valid  = 1'b1;
    req_funct3 = f3;
    req_pc     = pc;
    req_imm    = imm;
    in1        = a;
    in2        = b;
    @(negedge clk);
    req_valid  = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
    checks++; if (redir_valid !== 1'b0) begin failures++; $display("FAIL reset_redir_valid got=%b exp=0", redir_valid); end
    checks++; if (redir_pc !== 32'h0) begin failures++; $display("FAIL reset_redir_pc got=%h exp=0", redir_pc); end
    checks++; if ({flush, done, taken, err} !== 4'b0000) begin failures++; $display("FAIL reset_pulses got=%b exp=0000", {flush, done, taken, err}); end
    rst_n = 1'b1;
  endtask

  task automatic test_beq_taken();
    redir_ready = 1'b1;
    send(3'b000, 32'h100, 32'h20, 32'hA5A5A5A5, 32'hA5A5A5A5);
    checks++; if ({done, redir_valid, req_ready} !== 3'b000) begin failures++; $display("FAIL beq_cmp got=%b exp=000", {done, redir_valid, req_ready}); end
    @(negedge clk);
    checks++; if (redir_valid !== 1'b1) begin failures++; $display("FAIL beq_redir_valid got=%b exp=1", redir_valid); end
    checks++; if (redir_pc !== 32'h120) begin failures++; $display("FAIL beq_redir_pc got=%h exp=00000120", redir_pc); end
    checks++; if ({flush, done, taken, err} !== 4'b1110) begin failures++; $display("FAIL beq_handshake got=%b exp=1110", {flush, done, taken, err}); end
    @(negedge clk);
    checks++; if ({redir_valid, req_ready, flush} !== 3'b010) begin failures++; $display("FAIL beq_after got=%b exp=010", {redir_valid, req_ready, flush}); end
  endtask

  task automatic test_bne_not_taken();
    send(3'b001, 32'h200, 32'h40, 32'h12345678, 32'h12345678);
    checks++; if ({done, taken, err, flush, redir_valid} !== 5'b10000) begin failures++; $display("FAIL bne_cmp got=%b exp=10000", {done, taken, err, flush, redir_valid}); end
    @(negedge clk);
    checks++; if ({req_ready, done, redir_valid} !== 3'b100) begin failures++; $display("FAIL bne_after got=%b exp=100", {req_ready, done, redir_valid}); end
  endtask

  task automatic test_signed_unsigned();
    redir_ready = 1'b1;
    // -1 < 0 signed: taken
    send(3'b100, 32'h200, 32'h8, 32'hFFFFFFFF, 32'h0);
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL blt_cmp_done got=%b exp=0", done); end
    @(negedge clk);
    checks++; if ({redir_valid, taken, flush} !== 3'b111 || redir_pc !== 32'h208) begin failures++; $display("FAIL blt_issue got=%b pc=%h exp=111 pc=00000208", {redir_valid, taken, flush}, redir_pc); end
    // 0xFFFFFFFF < 0 unsigned: not taken
    send(3'b110, 32'h200, 32'h8, 32'hFFFFFFFF, 32'h0);
    checks++; if ({done, taken, err} !== 3'b100) begin failures++; $display("FAIL bltu_cmp got=%b exp=100", {done, taken, err}); end
    @(negedge clk);
    checks++; if (redir_valid !== 1'b0) begin failures++; $display("FAIL bltu_no_redir got=%b exp=0", redir_valid); end
  endtask

  task automatic test_wrap_backpressure();
    redir_ready = 1'b0;
    send(3'b101, 32'hFFFFFFF0, 32'h20, 32'h5, 32'h3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      // Requests offered during ISSUE must be ignored.
      req_valid = (i == 1); req_funct3 = 3'b000; req_pc = 32'hDEAD0000; in1 = 32'h0; in2 = 32'h0;
      checks++; if ({redir_valid, req_ready, flush, done} !== 4'b1000) begin failures++; $display("FAIL bge_wait%0d got=%b exp=1000", i, {redir_valid, req_ready, flush, done}); end
      checks++; if (redir_pc !== 32'h00000010) begin failures++; $display("FAIL bge_wait_pc%0d got=%h exp=00000010", i, redir_pc); end
    end
    req_valid   = 1'b0;
    redir_ready = 1'b1;
    #1;
    checks++; if ({flush, done, taken} !== 3'b111) begin failures++; $display("FAIL bge_handshake got=%b exp=111", {flush, done, taken}); end
    @(negedge clk);
    checks++; if ({redir_valid, req_ready, flush} !== 3'b010) begin failures++; $display("FAIL bge_after got=%b exp=010", {redir_valid, req_ready, flush}); end
  endtask

  task automatic test_errors();
    redir_ready = 1'b1;
    send(3'b010, 32'h100, 32'h20, 32'h1, 32'h1);
    checks++; if ({err, done, taken} !== 3'b110) begin failures++; $display("FAIL illegal_cmp got=%b exp=110", {err, done, taken}); end
    @(negedge clk);
    checks++; if ({redir_valid, req_ready, err} !== 3'b010) begin failures++; $display("FAIL illegal_after got=%b exp=010", {redir_valid, req_ready, err}); end
    send(3'b000, 32'h100, 32'h2, 32'h7, 32'h7);
    checks++; if ({err, done, taken} !== 3'b110) begin failures++; $display("FAIL misalign_cmp got=%b exp=110", {err, done, taken}); end
    @(negedge clk);
    checks++; if ({redir_valid, flush, req_ready} !== 3'b001) begin failures++; $display("FAIL misalign_after got=%b exp=001", {redir_valid, flush, req_ready}); end
`ifdef BRANCH_STATS_EN
    // taken: BEQ, BLT, BGE ; not-taken: BNE, BLTU, illegal, misaligned
    checks++; if (taken_cnt !== 16'd3 || ntaken_cnt !== 16'd4) begin failures++; $display("FAIL stats_counts got=%0d/%0d exp=3/4", taken_cnt, ntaken_cnt); end
`endif
  endtask

  task automatic test_reset_in_issue();
    redir_ready = 1'b0;
    send(3'b000, 32'h300, 32'h4, 32'h9, 32'h9);
    @(negedge clk);
    checks++; if (redir_valid !== 1'b1) begin failures++; $display("FAIL rst_pre_issue got=%b exp=1", redir_valid); end
    rst_n = 1'b0;
    #1;
    checks++; if ({redir_valid, req_ready, flush, done} !== 4'b0100 || redir_pc !== 32'h0) begin failures++; $display("FAIL rst_mid got=%b pc=%h exp=0100 pc=0", {redir_valid, req_ready, flush, done}, redir_pc); end
`ifdef BRANCH_STATS_EN
    checks++; if (taken_cnt !== 16'd0 || ntaken_cnt !== 16'd0) begin failures++; $display("FAIL rst_stats got=%0d/%0d exp=0/0", taken_cnt, ntaken_cnt); end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    redir_ready = 1'b1;
    @(negedge clk);
    checks++; if ({redir_valid, flush, req_ready} !== 3'b001) begin failures++; $display("FAIL rst_after got=%b exp=001", {redir_valid, flush, req_ready}); end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_funct3 = 3'b000; req_pc = '0;
    req_imm = '0; in1 = '0; in2 = '0; redir_ready = 1'b0;
    test_reset();
    test_beq_taken();
    test_bne_not_taken();
    test_signed_unsigned();
    test_wrap_backpressure();
    test_errors();
    test_reset_in_issue();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/branch_ctrl.md
Name: branch_ctrl

Overview:
Sequencing controller for branch resolution in the RV32I core. Accepts one conditional-branch request from decode via a valid/ready handshake and registers its operands. Evaluates the condition (BEQ/BNE/BLT/BGE/BLTU/BGEU) through a compare sub-module, computes the target, and on a taken branch issues a redirect plus a flush to fetch via a second valid/ready handshake. Sits between decode/register-read and the fetch PC mux.

Parameters:
XLEN, 32, operand and PC width
CNT_W, 16, width of the statistics counters (BRANCH_STATS_EN only)

Ports:
CLK  in  1  core clock, rising edge
RST_N  in  1  asynchronous active-low reset
REQ_VALID  in  1  branch request valid from decode
REQ_READY  out  1  controller can accept a request
REQ_FUNCT3  in  3  branch funct3 (000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU)
REQ_PC  in  XLEN  PC of the branch instruction
REQ_IMM  in  XLEN  sign-extended B-immediate
IN1  in  XLEN  rs1 value
IN2  in  XLEN  rs2 value
REDIR_VALID  out  1  redirect request to fetch
REDIR_READY  in  1  fetch accepts the redirect
REDIR_PC  out  XLEN  branch target
FLUSH  out  1  one-cycle pulse to kill younger instructions
DONE  out  1  one-cycle pulse when a branch resolves
TAKEN  out  1  resolution outcome, valid while DONE=1
ERR  out  1  one-cycle pulse for illegal funct3 or misaligned target

Behaviour:
- Reset: state IDLE. REQ_READY=1, all other outputs 0, REDIR_PC=0, operand registers 0.
- FSM states: IDLE, CMP, ISSUE.
- IDLE: REQ_READY=1. If REQ_VALID=1, latch FUNCT3, PC, IMM, IN1 and IN2, then go to CMP.
- CMP (one cycle): REQ_READY=0. Evaluate the condition on the latched operands. Target = PC+IMM mod 2^XLEN; carry is discarded, so wrap-around is legal.
  - funct3 010/011: ERR=1, DONE=1, TAKEN=0, go to IDLE.
  - Taken and target[1:0]!=00: ERR=1, DONE=1, TAKEN=0, no redirect, go to IDLE.
  - Taken and aligned: REDIR_PC=target registered, go to ISSUE.
  - Not taken: DONE=1, TAKEN=0, go to IDLE.
- ISSUE: REDIR_VALID=1 and REDIR_PC held stable until REDIR_READY=1.
  - Handshake cycle (REDIR_VALID&REDIR_READY): FLUSH=1, DONE=1, TAKEN=1.
  - Next cycle: REDIR_VALID=0, state IDLE.
  - While waiting, REQ_READY=0 (backpressure to decode).
- Latency: request accepted at cycle 0. Not-taken DONE at cycle 1. Earliest REDIR_VALID at cycle 2.
- Throughput: one request per 2 cycles (not-taken) or at least 3 cycles (taken).
- Signed compares (BLT/BGE) use two's complement; unsigned (BLTU/BGEU) use plain magnitude.
- REQ_VALID high outside IDLE is ignored; inputs are not sampled.
- RST_N asserted mid-operation (any state) returns to reset values immediately. A pending redirect is dropped and no FLUSH is generated.

Optional Feature:
BRANCH_STATS_EN
- Defined: adds outputs TAKEN_CNT[CNT_W] and NTAKEN_CNT[CNT_W]. Each increments on DONE with TAKEN=1 or TAKEN=0 respectively (ERR cases count as not-taken). Both saturate at all-ones and reset to 0.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package branch_pkg:
  - funct3 localparams F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU
  - state enum (IDLE, CMP, ISSUE)
  - XLEN default
- Sub-module branch_cmp_core: purely combinational. Inputs IN1, IN2, FUNCT3; outputs TAKE and ILLEGAL. It generalises the existing equality comparator to all six conditions.

Test Plan:
- BEQ, IN1=IN2=32'hA5A5A5A5, PC=32'h100, IMM=32'h20 -> REDIR_VALID at cycle 2 with REDIR_PC=32'h120. With REDIR_READY=1: FLUSH=1, DONE=1, TAKEN=1.
- BNE, IN1=IN2=32'h12345678 -> DONE=1, TAKEN=0 at cycle 1. REDIR_VALID and FLUSH stay 0. REQ_READY returns to 1 at cycle 2.
- BLT, IN1=32'hFFFFFFFF, IN2=0 -> taken. BLTU with the same operands -> not taken.
- Taken BGE, PC=32'hFFFFFFF0, IMM=32'h20 -> REDIR_PC=32'h00000010 (wrap). Hold REDIR_READY=0 for 3 cycles -> REDIR_VALID and REDIR_PC stable, REQ_READY=0, FLUSH only on the handshake cycle.
- funct3=010 -> ERR=1, DONE=1, no redirect. Taken BEQ with IMM=32'h2 -> ERR=1, no redirect.
- RST_N pulled low in ISSUE -> REDIR_VALID=0 immediately and REQ_READY=1. With BRANCH_STATS_EN, counters read 0.
